// File: rtl/nes_pad_reader.sv
// nes_pad_reader
// Serial NES/SNES gamepad reader. On each accepted poll it pulses the pad
// latch, clocks BITS active-low button bits in on nes_data and publishes an
// active-high button word plus a mask of buttons that are newly pressed.
//
// Ports
//   clk           system clock (25 MHz pixel clock)
//   reset         synchronous, active-high reset
//   poll          one-cycle read request, honoured only while idle
//   nes_data      serial pad data, active-low, asynchronous to clk
//   nes_latch     pad latch strobe, active-high
//   nes_clk       pad shift clock, idles low
//   buttons       last completed read, active-high, bit i = i-th serial bit
//   pressed_edge  buttons & ~previous buttons, updated together with buttons
//   valid         one-cycle pulse when buttons/pressed_edge update
//   busy          high from the cycle after poll acceptance through the valid cycle
module nes_pad_reader #(
  parameter int BITS      = 8,
  parameter int LATCH_CYC = 300,
  parameter int HALF_CYC  = 150
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            poll,
  input  logic            nes_data,
  output logic            nes_latch,
  output logic            nes_clk,
  output logic [BITS-1:0] buttons,
  output logic [BITS-1:0] pressed_edge,
  output logic            valid,
  output logic            busy
);

  localparam int MAX_CYC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int BIT_W   = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              sync_p0;
  logic              sync_p1;
  logic [BITS-1:0]   shift;
  logic [BITS-1:0]   shift_nxt;
  logic              latch_last;
  logic              half_last;
  logic              sample_now;
  logic              last_sample;
  logic              latch_nxt;
  logic              clk_nxt;
  logic              valid_nxt;
  logic              busy_nxt;

  assign latch_last  = (cnt == LATCH_LAST);
  assign half_last   = (cnt == HALF_LAST);
  assign sample_now  = (state == LOW) && half_last;
  assign last_sample = sample_now && (bit_idx == BIT_LAST);

  // Stage p0/p1: two-flop synchroniser on the asynchronous pad data
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= nes_data;
      sync_p1 <= sync_p0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (poll) state_nxt = LATCH;
      LATCH:   if (latch_last) state_nxt = LOW;
      LOW:     if (half_last) state_nxt = (bit_idx == BIT_LAST) ? DONE : HIGH;
      HIGH:    if (half_last) state_nxt = LOW;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the pins come straight off flops
  always_comb begin
    latch_nxt = (state_nxt == LATCH);
    clk_nxt   = (state_nxt == HIGH);
    valid_nxt = (state_nxt == DONE);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      nes_latch <= latch_nxt;
      nes_clk   <= clk_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Phase counter restarts from zero on every state change and rests at zero when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if ((state == IDLE) || (state_nxt != state)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if ((state == HIGH) && half_last) begin
        bit_idx <= bit_idx + BIT_W'(1);
      end
    end
  end

  // Shift register with the bit being sampled this cycle merged in, so the
  // final bit reaches buttons on the same edge that enters DONE
  always_comb begin
    shift_nxt = shift;
    if (sample_now) begin
      shift_nxt[bit_idx] = ~sync_p1;
    end
  end

  // Stage p2: sampled bits collect here, hidden until the read completes
  always_ff @(posedge clk) begin
    if (sample_now) begin
      shift <= shift_nxt;
    end
  end

  // Published word changes only when a full read completes; aborted reads leave no trace
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons      <= '0;
      pressed_edge <= '0;
    end else if (last_sample) begin
      buttons      <= shift_nxt;
      pressed_edge <= shift_nxt & ~buttons;
    end
  end

endmodule
